// File: rtl/branch_resolve_unit_pkg.sv
// Shared encodings for the branch resolve unit: op classes, condition codes,
// FSM states and flag bit positions inside {O,S,C,Z}.
package branch_resolve_unit_pkg;

  typedef enum logic [2:0] {
    OP_JF   = 3'b000,
    OP_JT   = 3'b001,
    OP_J    = 3'b010,
    OP_JAL  = 3'b011,
    OP_JR   = 3'b100,
    OP_NONE = 3'b111
  } op_tf_e;

  typedef enum logic [2:0] {
    COND_TRUE    = 3'b000,
    COND_NEG     = 3'b001,
    COND_ZERO    = 3'b010,
    COND_CARRY   = 3'b100,
    COND_NEGZERO = 3'b101,
    COND_OVF     = 3'b111
  } cond_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WAIT  = 2'b01,
    ST_FLUSH = 2'b10
  } state_e;

  localparam int FLAG_O = 3;
  localparam int FLAG_S = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 0;

  function automatic logic is_conditional(input logic [2:0] op);
    return (op == OP_JF) || (op == OP_JT);
  endfunction

endpackage

// File: rtl/branch_resolve_unit_cond_eval.sv
// Combinational branch decision: evaluates the condition against a flag set
// and classifies the op as taken / not taken / illegal.
module branch_resolve_unit_cond_eval
  import branch_resolve_unit_pkg::*;
(
  input  logic [3:0] i_flags,
  input  logic [2:0] i_op,
  input  logic [2:0] i_cond,
  output logic       o_taken,
  output logic       o_illegal
);

  logic w_c;
  logic w_cond_ok;

  always_comb begin
    w_c       = 1'b0;
    w_cond_ok = 1'b1;
    case (i_cond)
      COND_TRUE:    w_c = 1'b1;
      COND_NEG:     w_c = i_flags[FLAG_S];
      COND_ZERO:    w_c = i_flags[FLAG_Z];
      COND_CARRY:   w_c = i_flags[FLAG_C];
      COND_NEGZERO: w_c = i_flags[FLAG_S] & i_flags[FLAG_Z];
      COND_OVF:     w_c = i_flags[FLAG_O];
      default:      w_cond_ok = 1'b0;
    endcase
  end

  always_comb begin
    o_taken   = 1'b0;
    o_illegal = 1'b0;
    case (i_op)
      OP_JF: begin
        if (w_cond_ok) o_taken = ~w_c;
        else           o_illegal = 1'b1;
      end
      OP_JT: begin
        if (w_cond_ok) o_taken = w_c;
        else           o_illegal = 1'b1;
      end
      OP_J, OP_JAL, OP_JR: o_taken = 1'b1;
      OP_NONE:             o_taken = 1'b0;
      default:             o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: architectural flag register with same-cycle bypass,
// handshaked branch resolution, flag-pending stall and timed pipeline flush.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  BR_VALID,
  output logic                  BR_READY,
  input  logic [2:0]            OP_TF,
  input  logic [2:0]            COND,
  input  logic [ADDR_WIDTH-1:0] TARGET,
  input  logic                  FLAG_WE,
  input  logic                  O_IN,
  input  logic                  S_IN,
  input  logic                  C_IN,
  input  logic                  Z_IN,
  input  logic                  FLAG_PENDING,
  output logic [3:0]            FLAGS_Q,
  output logic                  RESOLVED,
  output logic                  TAKEN,
  output logic                  SEL_PC,
  output logic [ADDR_WIDTH-1:0] PC_OUT,
  output logic                  FLUSH,
  output logic                  ILLEGAL,
  output logic [CNT_WIDTH-1:0]  TAKEN_CNT
);

  localparam int FCW = $clog2(FLUSH_CYCLES + 1);

  state_e                r_state;
  state_e                w_next_state;
  logic [3:0]            r_flags;
  logic [3:0]            w_new_flags;
  logic [3:0]            w_eval_flags;
  logic [2:0]            r_op;
  logic [2:0]            r_cond;
  logic [ADDR_WIDTH-1:0] r_target;
  logic [2:0]            w_op_sel;
  logic [2:0]            w_cond_sel;
  logic [ADDR_WIDTH-1:0] w_target_sel;
  logic [FCW-1:0]        r_flush_cnt;
  logic                  w_accept;
  logic                  w_go_wait;
  logic                  w_resolve;
  logic                  w_taken;
  logic                  w_illegal;
  logic                  w_flush_next;

  assign w_new_flags  = {O_IN, S_IN, C_IN, Z_IN};
  assign w_eval_flags = FLAG_WE ? w_new_flags : r_flags;
  assign w_accept     = BR_VALID & (r_state == ST_IDLE);
  assign w_go_wait    = w_accept & is_conditional(OP_TF) & FLAG_PENDING & ~FLAG_WE;

  // In WAIT the decision uses the captured request, otherwise the live one
  assign w_op_sel     = (r_state == ST_WAIT) ? r_op     : OP_TF;
  assign w_cond_sel   = (r_state == ST_WAIT) ? r_cond   : COND;
  assign w_target_sel = (r_state == ST_WAIT) ? r_target : TARGET;

  branch_resolve_unit_cond_eval u_cond_eval (
    .i_flags   (w_eval_flags),
    .i_op      (w_op_sel),
    .i_cond    (w_cond_sel),
    .o_taken   (w_taken),
    .o_illegal (w_illegal)
  );

  always_comb begin
    w_resolve = 1'b0;
    case (r_state)
      ST_IDLE: w_resolve = w_accept & (OP_TF != OP_NONE) & ~w_go_wait;
      ST_WAIT: w_resolve = FLAG_WE | ~FLAG_PENDING;
      default: w_resolve = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_resolve && w_taken) w_next_state = ST_FLUSH;
        else if (w_go_wait)       w_next_state = ST_WAIT;
        else                      w_next_state = ST_IDLE;
      end
      ST_WAIT: begin
        if (w_resolve) w_next_state = w_taken ? ST_FLUSH : ST_IDLE;
        else           w_next_state = ST_WAIT;
      end
      ST_FLUSH: begin
        if (r_flush_cnt == '0) w_next_state = ST_IDLE;
        else                   w_next_state = ST_FLUSH;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // FLUSH lags RESOLVED by one cycle, so the counter is loaded on the resolve edge
  always_comb begin
    w_flush_next = 1'b0;
    case (r_state)
      ST_FLUSH: w_flush_next = (r_flush_cnt != '0);
      default:  w_flush_next = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_flags     <= 4'b0000;
      r_op        <= OP_NONE;
      r_cond      <= COND_TRUE;
      r_target    <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (FLAG_WE) r_flags <= w_new_flags;
      if (w_go_wait) begin
        r_op     <= OP_TF;
        r_cond   <= COND;
        r_target <= TARGET;
      end
      if (w_resolve && w_taken)
        r_flush_cnt <= FCW'(FLUSH_CYCLES);
      else if (r_state == ST_FLUSH && r_flush_cnt != '0)
        r_flush_cnt <= r_flush_cnt - FCW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      RESOLVED  <= 1'b0;
      ILLEGAL   <= 1'b0;
      TAKEN     <= 1'b0;
      SEL_PC    <= 1'b1;
      PC_OUT    <= '0;
      FLUSH     <= 1'b0;
      TAKEN_CNT <= '0;
    end else begin
      RESOLVED <= w_resolve;
      ILLEGAL  <= w_resolve & w_illegal;
      FLUSH    <= w_flush_next;
      if (w_resolve) begin
        TAKEN  <= w_taken;
        SEL_PC <= ~w_taken;
      end
      if (w_resolve && w_taken) begin
        PC_OUT <= w_target_sel;
        if (TAKEN_CNT != {CNT_WIDTH{1'b1}}) TAKEN_CNT <= TAKEN_CNT + CNT_WIDTH'(1);
      end
    end
  end

  assign BR_READY = (r_state == ST_IDLE);
  assign FLAGS_Q  = r_flags;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench: directed scenarios plus random traffic, every cycle
// compared against a transaction-level reference model.
module tb_branch_resolve_unit;

  localparam int AW = 16;
  localparam int FC = 2;
  localparam int CW = 2;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          BR_VALID, BR_READY;
  logic [2:0]    OP_TF, COND;
  logic [AW-1:0] TARGET;
  logic          FLAG_WE, O_IN, S_IN, C_IN, Z_IN, FLAG_PENDING;
  logic [3:0]    FLAGS_Q;
  logic          RESOLVED, TAKEN, SEL_PC, FLUSH, ILLEGAL;
  logic [AW-1:0] PC_OUT;
  logic [CW-1:0] TAKEN_CNT;

  branch_resolve_unit #(.ADDR_WIDTH(AW), .FLUSH_CYCLES(FC), .CNT_WIDTH(CW)) dut (
    .CLK(CLK), .RESET(RESET), .BR_VALID(BR_VALID), .BR_READY(BR_READY),
    .OP_TF(OP_TF), .COND(COND), .TARGET(TARGET), .FLAG_WE(FLAG_WE),
    .O_IN(O_IN), .S_IN(S_IN), .C_IN(C_IN), .Z_IN(Z_IN),
    .FLAG_PENDING(FLAG_PENDING), .FLAGS_Q(FLAGS_Q), .RESOLVED(RESOLVED),
    .TAKEN(TAKEN), .SEL_PC(SEL_PC), .PC_OUT(PC_OUT), .FLUSH(FLUSH),
    .ILLEGAL(ILLEGAL), .TAKEN_CNT(TAKEN_CNT)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state: what the unit is doing, expressed as a pending
  // request and a count of cycles during which requests are refused.
  logic [3:0]    m_flags;
  bit            m_waiting;
  logic [2:0]    m_op, m_cond;
  logic [AW-1:0] m_tgt;
  int            m_busy;
  bit            m_resolved, m_illegal, m_taken;
  logic [AW-1:0] m_pc;
  int            m_cnt;

  function automatic logic [1:0] decide(input logic [3:0] f, input logic [2:0] op, input logic [2:0] cond);
    bit cv, ok;
    ok = 1; cv = 0;
    case (cond)
      3'd0: cv = 1;
      3'd1: cv = f[2];
      3'd2: cv = f[0];
      3'd4: cv = f[1];
      3'd5: cv = f[2] & f[0];
      3'd7: cv = f[3];
      default: ok = 0;
    endcase
    case (op)
      3'd7:             return 2'b00;
      3'd2, 3'd3, 3'd4: return 2'b10;
      3'd0, 3'd1: begin
        if (!ok) return 2'b01;
        return {((op == 3'd1) ? cv : !cv), 1'b0};
      end
      default:          return 2'b01;
    endcase
  endfunction

  task automatic model_reset();
    m_flags = 0; m_waiting = 0; m_busy = 0; m_resolved = 0; m_illegal = 0;
    m_taken = 0; m_pc = 0; m_cnt = 0; m_op = 3'd7; m_cond = 3'd0; m_tgt = 0;
  endtask

  task automatic model_resolve(input logic [3:0] f, input logic [2:0] op, input logic [2:0] cond, input logic [AW-1:0] tgt);
    logic [1:0] d;
    d = decide(f, op, cond);
    m_resolved = 1; m_illegal = d[0]; m_taken = d[1]; m_waiting = 0;
    if (d[1]) begin
      m_pc = tgt;
      if (m_cnt < (1 << CW) - 1) m_cnt++;
      m_busy = FC + 1;
    end
  endtask

  // Evaluated just before a rising edge with the inputs currently driven
  task automatic model_step();
    logic [3:0] ev;
    ev = FLAG_WE ? {O_IN, S_IN, C_IN, Z_IN} : m_flags;
    m_resolved = 0; m_illegal = 0;
    if (m_busy > 0) m_busy--;
    else if (m_waiting) begin
      if (FLAG_WE || !FLAG_PENDING) model_resolve(ev, m_op, m_cond, m_tgt);
    end else if (BR_VALID) begin
      if (OP_TF == 3'd7) begin
      end else if ((OP_TF == 3'd0 || OP_TF == 3'd1) && FLAG_PENDING && !FLAG_WE) begin
        m_waiting = 1; m_op = OP_TF; m_cond = COND; m_tgt = TARGET;
      end else model_resolve(ev, OP_TF, COND, TARGET);
    end
    if (FLAG_WE) m_flags = {O_IN, S_IN, C_IN, Z_IN};
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".ready"},    BR_READY,  (m_busy == 0 && !m_waiting));
    check({tag, ".resolved"}, RESOLVED,  m_resolved);
    check({tag, ".illegal"},  ILLEGAL,   m_illegal);
    check({tag, ".taken"},    TAKEN,     m_taken);
    check({tag, ".sel_pc"},   SEL_PC,    !m_taken);
    check({tag, ".pc_out"},   PC_OUT,    m_pc);
    check({tag, ".flush"},    FLUSH,     (m_busy > 0 && m_busy <= FC));
    check({tag, ".cnt"},      TAKEN_CNT, m_cnt);
    check({tag, ".flags"},    FLAGS_Q,   m_flags);
  endtask

  task automatic cyc(input string tag, input bit v, input logic [2:0] op, input logic [2:0] cond,
                     input logic [AW-1:0] tgt, input bit we, input logic [3:0] f, input bit pend);
    BR_VALID = v; OP_TF = op; COND = cond; TARGET = tgt; FLAG_WE = we;
    {O_IN, S_IN, C_IN, Z_IN} = f; FLAG_PENDING = pend;
    model_step();
    @(posedge CLK); #1;
    compare_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 0, 3'd7, 3'd0, '0, 0, 4'h0, 0);
  endtask

  task automatic do_reset();
    RESET = 1; BR_VALID = 0; OP_TF = 3'd7; COND = 0; TARGET = 0; FLAG_WE = 0;
    {O_IN, S_IN, C_IN, Z_IN} = 4'h0; FLAG_PENDING = 0;
    model_reset();
    @(posedge CLK); #1;
    RESET = 0;
    compare_all("reset");
  endtask

  initial begin
    do_reset();
    check("reset.sel_pc_is_1", SEL_PC, 1'b1);

    // Taken jt.zero with flush window
    cyc("t1.flags", 0, 3'd7, 3'd0, '0, 1, 4'b0001, 0);
    cyc("t1.br", 1, 3'd1, 3'd2, 16'h0040, 0, 4'h0, 0);
    check("t1.pc", PC_OUT, 16'h0040);
    check("t1.res", RESOLVED, 1'b1);
    check("t1.flush_first", FLUSH, 1'b0);
    cyc("t1.f1", 1, 3'd2, 3'd0, 16'hDEAD, 0, 4'h0, 0);
    check("t1.flush1", FLUSH, 1'b1);
    idle("t1.f2", 2);
    check("t1.ready_back", BR_READY, 1'b1);

    // Same-cycle bypass: jf.zero sees Z_IN=1
    cyc("t2.clr", 0, 3'd7, 3'd0, '0, 1, 4'b0000, 0);
    cyc("t2.br", 1, 3'd0, 3'd2, 16'h1111, 1, 4'b0001, 0);
    check("t2.taken", TAKEN, 1'b0);
    idle("t2.idle", 2);

    // Stall on pending flags
    cyc("t3.br", 1, 3'd1, 3'd4, 16'h0123, 0, 4'h0, 1);
    check("t3.wait_ready", BR_READY, 1'b0);
    for (int i = 0; i < 3; i++) cyc("t3.hold", 1, 3'd2, 3'd0, 16'hBEEF, 0, 4'h0, 1);
    cyc("t3.fw", 0, 3'd7, 3'd0, '0, 1, 4'b0010, 1);
    check("t3.pc", PC_OUT, 16'h0123);
    idle("t3.idle", 3);

    // Illegal encodings
    cyc("t4.cond011", 1, 3'd1, 3'd3, 16'h2222, 0, 4'h0, 0);
    check("t4.illegal", ILLEGAL, 1'b1);
    cyc("t4.op110", 1, 3'd6, 3'd0, 16'h3333, 0, 4'h0, 0);
    check("t4.illegal2", ILLEGAL, 1'b1);
    idle("t4.idle", 1);

    // Async reset in the first flush cycle
    cyc("t5.j", 1, 3'd2, 3'd0, 16'h0500, 0, 4'h0, 0);
    idle("t5.res", 1);
    check("t5.flush_on", FLUSH, 1'b1);
    #2 RESET = 1;
    #1;
    model_reset();
    check("t5.flush_off", FLUSH, 1'b0);
    check("t5.sel_pc", SEL_PC, 1'b1);
    @(posedge CLK); #1;
    RESET = 0;
    cyc("t5.j2", 1, 3'd2, 3'd0, 16'h0600, 0, 4'h0, 0);
    check("t5.resolved", RESOLVED, 1'b1);

    // Counter saturation with five taken jumps
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc("t6.j", 1, 3'd2, 3'd0, AW'(i), 0, 4'h0, 0);
      idle("t6.gap", FC + 1);
    end
    check("t6.cnt_sat", TAKEN_CNT, 2'd3);

    // Random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] op;
      int r;
      r  = $urandom_range(0, 10);
      op = (r > 7) ? 3'(r & 1) : 3'(r);
      cyc("rnd", ($urandom_range(0, 1) == 1), op, 3'($urandom_range(0, 7)), AW'($urandom),
          ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
